// File: rtl/register_file_sync_read.sv
// register_file_sync_read: 2R1W register file with registered reads and a post-reset clear sequencer
module register_file_sync_read #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int DEPTH     = 2**ADDR_BITS,
  parameter bit BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr1,
  input  logic [ADDR_BITS-1:0] raddr2,
  output logic [WIDTH-1:0]     rdata1,
  output logic [WIDTH-1:0]     rdata2,
  output logic                 busy,
  output logic                 dropped
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_next;
  logic [ADDR_BITS-1:0] cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic last;
  assign last = cnt == ADDR_BITS'(DEPTH - 1);
  function automatic logic [WIDTH-1:0] rd(input logic [ADDR_BITS-1:0] a);
    return a == '0 ? '0 : (BYPASS && we && waddr == a) ? wdata : mem[a];
  endfunction
  always_ff @(posedge clk) state <= reset ? CLEAR : state_next;
  always_comb state_next = (state == CLEAR && last) ? READY : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      rdata1  <= '0;
      rdata2  <= '0;
      busy    <= 1'b1;
      dropped <= 1'b0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
      cnt      <= cnt + 1'b1;
      busy     <= !last;
      dropped  <= we;
      rdata1   <= '0;
      rdata2   <= '0;
    end else begin
      if (we && waddr != '0) mem[waddr] <= wdata;
      dropped <= 1'b0;
      rdata1  <= rd(raddr1);
      rdata2  <= rd(raddr2);
    end
  end
endmodule

// File: tb/tb_register_file_sync_read.sv
// tb_register_file_sync_read: random and directed checks of both bypass variants against an array model
module tb_register_file_sync_read;
  logic clk = 0;
  logic reset = 1, we = 0;
  logic [4:0] waddr = 0, raddr1 = 0, raddr2 = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata1, rdata2, rdata1_n, rdata2_n;
  logic busy, dropped, busy_n, dropped_n;
  int checks = 0, errors = 0;
  logic [31:0] m [32];
  int clear_left = 0;
  logic [31:0] e1, e2, e1n, e2n;
  logic ebusy, edrop;

  always #5 clk = ~clk;

  register_file_sync_read #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .busy(busy), .dropped(dropped));
  register_file_sync_read #(.BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_n), .rdata2(rdata2_n),
    .busy(busy_n), .dropped(dropped_n));

  // Model: clear_left counts remaining clear cycles; reads see the array before this edge's write
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      clear_left = 32;
      {e1, e2, e1n, e2n} = '0;
      ebusy = 1;
      edrop = 0;
    end else if (clear_left > 0) begin
      m[32 - clear_left] = 0;
      clear_left--;
      ebusy = clear_left > 0;
      edrop = we;
      {e1, e2, e1n, e2n} = '0;
    end else begin
      e1n = raddr1 == 0 ? 0 : m[raddr1];
      e2n = raddr2 == 0 ? 0 : m[raddr2];
      e1 = (raddr1 != 0 && we && waddr == raddr1) ? wdata : e1n;
      e2 = (raddr2 != 0 && we && waddr == raddr2) ? wdata : e2n;
      if (we && waddr != 0) m[waddr] = wdata;
      edrop = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    int n = 0;
    reset = 1;
    tick();
    checks++;
    if (busy !== 1 || dropped !== 0 || rdata1 !== 0 || rdata2 !== 0) begin
      errors++;
      $display("FAIL reset_state busy=%b dropped=%b rd1=%h rd2=%h exp 1 0 0 0", busy, dropped, rdata1, rdata2);
    end
    reset = 0;
    while (busy === 1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 32 || busy_n !== 0) begin
      errors++;
      $display("FAIL busy_len got %0d cycles (busy_n=%b) exp 32", n, busy_n);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      tick();
      checks++;
      if (rdata1 !== 0 || rdata2 !== 0 || rdata1_n !== 0 || rdata2_n !== 0) begin
        errors++;
        $display("FAIL clear_read a=%0d rd1=%h rd2=%h exp 0", i, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1; waddr = 5; wdata = 32'hDEADBEEF;
    tick();
    we = 0; raddr1 = 5;
    tick();
    checks++;
    if (rdata1 !== 32'hDEADBEEF || rdata1 !== e1 || rdata1_n !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read rd1=%h rd1_n=%h exp deadbeef", rdata1, rdata1_n);
    end
  endtask

  task automatic test_r0();
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr1 = 0; raddr2 = 0;
    tick();
    checks++;
    if (rdata1 !== 0 || rdata2 !== 0 || dropped !== 0) begin
      errors++;
      $display("FAIL r0_same rd1=%h rd2=%h dropped=%b exp 0 0 0", rdata1, rdata2, dropped);
    end
    we = 0;
    tick();
    checks++;
    if (rdata1 !== 0 || rdata2 !== 0 || rdata1_n !== 0 || dropped !== 0) begin
      errors++;
      $display("FAIL r0_after rd1=%h rd2=%h dropped=%b exp 0 0 0", rdata1, rdata2, dropped);
    end
  endtask

  task automatic test_bypass();
    we = 1; waddr = 7; wdata = 32'h11111111;
    tick();
    wdata = 32'h12345678; raddr2 = 7;
    tick();
    we = 0;
    checks++;
    if (rdata2 !== 32'h12345678 || rdata2_n !== 32'h11111111 || rdata2 !== e2 || rdata2_n !== e2n) begin
      errors++;
      $display("FAIL bypass rd2=%h exp 12345678, rd2_n=%h exp 11111111", rdata2, rdata2_n);
    end
  endtask

  task automatic test_drop();
    int n;
    reset = 1; tick(); reset = 0;
    repeat (5) tick();
    reset = 1; tick(); reset = 0;
    repeat (10) tick();
    we = 1; waddr = 9; wdata = 32'hCAFEF00D;
    tick();
    checks++;
    if (dropped !== 1 || dropped_n !== 1 || busy !== 1) begin
      errors++;
      $display("FAIL drop_pulse dropped=%b busy=%b exp 1 1", dropped, busy);
    end
    we = 0;
    tick();
    checks++;
    if (dropped !== 0) begin
      errors++;
      $display("FAIL drop_end dropped=%b exp 0", dropped);
    end
    n = 12;
    while (busy === 1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL restart_len got %0d cycles exp 32", n);
    end
    raddr1 = 9;
    tick();
    checks++;
    if (rdata1 !== 0 || rdata1_n !== 0) begin
      errors++;
      $display("FAIL drop_target rd1=%h exp 0", rdata1);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom);
      waddr = (i % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      raddr1 = (i % 3) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      raddr2 = 5'($urandom);
      if (i % 5 == 0) raddr2 = waddr;
      wdata = $urandom;
      tick();
      checks++;
      if (rdata1 !== e1 || rdata2 !== e2 || rdata1_n !== e1n || rdata2_n !== e2n ||
          busy !== ebusy || dropped !== edrop) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL random i=%0d rd1=%h/%h rd2=%h/%h rd1n=%h/%h rd2n=%h/%h busy=%b/%b drop=%b/%b (got/exp)",
                   i, rdata1, e1, rdata2, e2, rdata1_n, e1n, rdata2_n, e2n, busy, ebusy, dropped, edrop);
      end
    end
    we = 0;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    for (int i = 1; i < 32; i++) begin
      we = 1; waddr = 5'(i); wdata = 32'hA5A50000 + i;
      tick();
    end
    we = 0;
    raddr1 = 17; raddr2 = 31;
    tick();
    checks++;
    if (rdata1 !== 32'hA5A50011 || rdata2 !== 32'hA5A5001F) begin
      errors++;
      $display("FAIL fill rd1=%h rd2=%h exp a5a50011 a5a5001f", rdata1, rdata2);
    end
    repeat ($urandom_range(1, 10)) tick();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 32; i++) begin
      we = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
      tick();
    end
    we = 0;
    checks++;
    if (busy !== 0 || busy_n !== 0) begin
      errors++;
      $display("FAIL clear_done busy=%b exp 0", busy);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      tick();
      checks++;
      if (rdata1 !== 0 || rdata2 !== 0 || rdata1_n !== 0 || rdata2_n !== 0) begin
        errors++;
        if (bad++ < 5) $display("FAIL post_clear a=%0d rd1=%h rd2=%h exp 0", i, rdata1, rdata2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_drop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
